// File: rtl/aes_decrypt_iter.sv
// Iterative AES inverse cipher: one shared round per clock, Nr rounds per block,
// with a ready/valid handshake on both sides and zero-bubble hand-off from DONE.
module aes_decrypt_iter #(
    parameter int unsigned Nk = 4,
    parameter int unsigned Nr = Nk + 6
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [127:0]          data,
    input  logic [(Nr+1)*128-1:0] allKeys,
    output logic [127:0]          out,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic                  busy
);

    localparam int unsigned BW = 128;
    localparam int unsigned CW = $clog2(Nr + 1);

    if (!((Nk == 4 || Nk == 6 || Nk == 8) && Nr == Nk + 6)) begin : g_bad_param
        $error("aes_decrypt_iter: Nk must be 4, 6 or 8 and Nr must equal Nk+6");
    end

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ROUND = 2'd1,
        DONE  = 2'd2
    } fsm_t;

    // GF(2^8) multiply modulo x^8+x^4+x^3+x+1
    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] aa;
        p  = 8'h00;
        aa = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ aa;
            aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    // Inverse S-box: undo the affine map, then field inverse as x^254
    function automatic logic [7:0] inv_sbox(input logic [7:0] x);
        logic [7:0] y;
        logic [7:0] r;
        y = {x[6:0], x[7]} ^ {x[4:0], x[7:5]} ^ {x[1:0], x[7:2]} ^ 8'h05;
        r = y;
        for (int i = 0; i < 6; i++) begin
            r = gf_mul(gf_mul(r, r), y);
        end
        return gf_mul(r, r);
    endfunction

    function automatic logic [31:0] inv_mix_col(input logic [31:0] col);
        logic [7:0] a0, a1, a2, a3;
        a0 = col[31:24];
        a1 = col[23:16];
        a2 = col[15:8];
        a3 = col[7:0];
        return {gf_mul(a0, 8'h0e) ^ gf_mul(a1, 8'h0b) ^ gf_mul(a2, 8'h0d) ^ gf_mul(a3, 8'h09),
                gf_mul(a0, 8'h09) ^ gf_mul(a1, 8'h0e) ^ gf_mul(a2, 8'h0b) ^ gf_mul(a3, 8'h0d),
                gf_mul(a0, 8'h0d) ^ gf_mul(a1, 8'h09) ^ gf_mul(a2, 8'h0e) ^ gf_mul(a3, 8'h0b),
                gf_mul(a0, 8'h0b) ^ gf_mul(a1, 8'h0d) ^ gf_mul(a2, 8'h09) ^ gf_mul(a3, 8'h0e)};
    endfunction

    fsm_t          fsm_q, fsm_d;
    logic [BW-1:0] st_q, st_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [BW-1:0] out_d;
    logic          out_valid_d;
    logic          busy_d;

    logic [BW-1:0] keys [Nr+1];
    logic [BW-1:0] rkey;
    logic [7:0]    ark [16];
    logic [BW-1:0] round_mid;
    logic [BW-1:0] round_last;

    // Round key i sits at slice (Nr-i); the cipher key is the top slice
    for (genvar i = 0; i <= Nr; i++) begin : g_keys
        assign keys[i] = allKeys[(Nr - i)*BW +: BW];
    end

    assign rkey = keys[cnt_q];

    // InvShiftRows + InvSubBytes + AddRoundKey; byte n = row n%4, column n/4
    for (genvar n = 0; n < 16; n++) begin : g_byte
        localparam int unsigned SRC = (n % 4) + 4 * (((n / 4) + 4 - (n % 4)) % 4);
        assign ark[n] = inv_sbox(st_q[BW-1-8*SRC -: 8]) ^ rkey[BW-1-8*n -: 8];
        assign round_last[BW-1-8*n -: 8] = ark[n];
    end

    for (genvar c = 0; c < 4; c++) begin : g_col
        assign round_mid[BW-1-32*c -: 32] =
            inv_mix_col({ark[4*c], ark[4*c+1], ark[4*c+2], ark[4*c+3]});
    end

    // Next-state and handshake decode
    always_comb begin
        fsm_d       = fsm_q;
        st_d        = st_q;
        cnt_d       = cnt_q;
        out_d       = out;
        out_valid_d = out_valid;
        in_ready    = 1'b0;
        case (fsm_q)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    st_d  = data ^ keys[Nr];
                    cnt_d = CW'(Nr - 1);
                    fsm_d = ROUND;
                end
            end
            ROUND: begin
                if (cnt_q == '0) begin
                    out_d       = round_last;
                    out_valid_d = 1'b1;
                    fsm_d       = DONE;
                end else begin
                    st_d  = round_mid;
                    cnt_d = cnt_q - CW'(1);
                end
            end
            DONE: begin
                in_ready = out_ready;
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    fsm_d       = IDLE;
                    // Hand-off: retire the result and accept the next block on one edge
                    if (in_valid) begin
                        st_d  = data ^ keys[Nr];
                        cnt_d = CW'(Nr - 1);
                        fsm_d = ROUND;
                    end
                end
            end
            default: fsm_d = IDLE;
        endcase
        busy_d = (fsm_d == ROUND);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            fsm_q     <= IDLE;
            st_q      <= '0;
            cnt_q     <= '0;
            out       <= '0;
            out_valid <= 1'b0;
            busy      <= 1'b0;
        end else begin
            fsm_q     <= fsm_d;
            st_q      <= st_d;
            cnt_q     <= cnt_d;
            out       <= out_d;
            out_valid <= out_valid_d;
            busy      <= busy_d;
        end
    end

endmodule

// File: doc/aes_decrypt_iter.md
AES_DECRYPT_ITER -- requirements
Module: aes_decrypt_iter

Interface
REQ-001 Parameter Nk, default 4, key length in 32-bit words; legal values 4, 6, 8 (AES-128/192/256).
REQ-002 Parameter Nr, default Nk+6, round count; any value other than Nk+6, or any Nk outside {4,6,8}, SHALL fail elaboration.
REQ-003 clk  input  1  rising-edge clock for all state.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 in_valid  input  1  data and allKeys are valid for acceptance.
REQ-006 in_ready  output  1  block can accept a new ciphertext.
REQ-007 data  input  128  ciphertext block.
REQ-008 allKeys  input  (Nr+1)*128  expanded schedule; round-i key = allKeys[(Nr+1-i)*128-1 -: 128], so the round-0 (cipher) key is the top slice.
REQ-009 out  output  128  plaintext result register.
REQ-010 out_valid  output  1  out holds a completed plaintext.
REQ-011 out_ready  input  1  downstream accepts out this cycle.
REQ-012 busy  output  1  a block is in progress (ROUND state).

Function
REQ-013 The block SHALL implement FSM states IDLE, ROUND, DONE.
REQ-014 Acceptance: a rising edge with in_valid=1 and in_ready=1.
REQ-015 in_ready SHALL be 1 in IDLE, 0 in ROUND, and equal to out_ready in DONE.
REQ-016 On acceptance the block SHALL load state <= data XOR key[Nr], load round counter <= Nr-1, and enter ROUND.
REQ-017 In ROUND with counter c>0, each edge SHALL apply InvShiftRows, InvSubBytes, AddRoundKey(key[c]), InvMixColumns, then decrement c.
REQ-018 In ROUND with c=0, the edge SHALL apply InvShiftRows, InvSubBytes, AddRoundKey(key[0]), write the result to out, set out_valid=1, and enter DONE.
REQ-019 Latency SHALL be exactly Nr edges from the acceptance edge to the out_valid rising edge: 10, 12, or 14 edges for Nk=4, 6, 8.
REQ-020 allKeys SHALL be sampled combinationally each round; the upstream SHALL hold allKeys stable from acceptance until out_valid, while data is needed only at acceptance.
REQ-021 In DONE, out and out_valid SHALL hold unchanged while out_ready=0.
REQ-022 In DONE with out_ready=1 and in_valid=0, the block SHALL clear out_valid and enter IDLE; out SHALL keep its last value.
REQ-023 In DONE with out_ready=1 and in_valid=1, the block SHALL hand off and accept in the same edge: out_valid cleared, and the new block loaded per REQ-016, giving zero-bubble back-to-back throughput of one block per Nr+1 cycles.
REQ-024 in_valid SHALL be ignored while in ROUND; no acceptance, no state change.
REQ-025 busy SHALL be 1 exactly when the FSM is in ROUND.
REQ-026 The round datapath SHALL be a single combinational round, reused every cycle and selected by state.

Reset
REQ-027 reset=1 SHALL immediately, without waiting for a clock, force IDLE, state=0, counter=0, out=0, out_valid=0, busy=0, and in_ready=1 after release.
REQ-028 reset asserted mid-operation SHALL abort the block with no out_valid pulse; the first edge after release SHALL be able to accept.

Verification
REQ-029 Nk=4: key schedule from 000102030405060708090a0b0c0d0e0f, data 69c4e0d86a7b0430d8cdb78070b4c55a -> out 00112233445566778899aabbccddeeff with out_valid on edge 10 after acceptance.
REQ-030 Nk=6: key 000102...1617, data dda97ca4864cdfe06eaf70a0ec0d7191 -> out 00112233445566778899aabbccddeeff after 12 edges.
REQ-031 Nk=8: key 000102...1e1f, data 8ea2b7ca516745bfeafc49904b496089 -> out 00112233445566778899aabbccddeeff after 14 edges.
REQ-032 Backpressure: out_ready held 0 for 5 cycles after completion -> out/out_valid stable, in_ready=0, then out_ready=1 with in_valid=1 -> accepted same edge, second result correct 10 edges later.
REQ-033 Reset mid-round: assert reset on edge 5 of an Nk=4 block -> out=0, out_valid=0, busy=0 instantly; a new block after release decrypts correctly.
REQ-034 in_valid pulsed during ROUND with different data -> ignored; original result unchanged.
